// File: rtl/irq_receiver.sv
// Core-side responder for the irq req/code/ack handshake: acknowledges a request,
// raises a trap with a computed vector and blocks new requests until the handler returns.
module irq_receiver #(
   parameter int          CNT_W   = 16,
   parameter logic [31:0] VEC_RST = 32'h0000_0100
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        irq_req_i,
   input  logic [7:0]  irq_code_bi,
   output logic        irq_ack_o,
   input  logic        cfg_we_i,
   input  logic [1:0]  cfg_addr_i,
   input  logic [31:0] cfg_wdata_bi,
   output logic [31:0] cfg_rdata_bo,
   output logic        trap_req_o,
   output logic [31:0] trap_vec_bo,
   output logic [7:0]  trap_code_bo,
   input  logic        trap_taken_i,
   input  logic        irq_ret_i,
   output logic        busy_o
);

   // state   | meaning
   // IDLE    | waiting for an enabled request
   // ACK     | one-cycle ack; decide spurious vs trap
   // TRAP    | trap request held until the core takes it
   // SERVICE | handler running; waiting for return
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ACK     = 2'd1;
   localparam logic [1:0] S_TRAP    = 2'd2;
   localparam logic [1:0] S_SERVICE = 2'd3;

   localparam logic [1:0] A_CTRL = 2'd0;
   localparam logic [1:0] A_VEC  = 2'd1;
   localparam logic [1:0] A_SRV  = 2'd2;
   localparam logic [1:0] A_SPUR = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [1:0]       state;
   logic             enable;
   logic [31:0]      vec_base;
   logic [CNT_W-1:0] srv_cnt;
   logic [CNT_W-1:0] spur_cnt;
   logic [7:0]       code_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         enable       <= 1'b0;
         vec_base     <= VEC_RST;
         srv_cnt      <= '0;
         spur_cnt     <= '0;
         code_q       <= 8'h00;
         trap_vec_bo  <= 32'h0;
         trap_code_bo <= 8'h00;
      end else begin
         if (cfg_we_i) begin
            case (cfg_addr_i)
               A_CTRL:  enable   <= cfg_wdata_bi[0];
               A_VEC:   vec_base <= cfg_wdata_bi & 32'hFFFF_FFFC;
               default: ;
            endcase
         end

         case (state)
            S_IDLE: begin
               // enable is the registered value, so a same-cycle CTRL write has no effect yet
               if (enable && irq_req_i) begin
                  code_q <= irq_code_bi;
                  state  <= S_ACK;
               end
            end
            S_ACK: begin
               if (code_q == 8'h00) begin
                  spur_cnt <= spur_cnt + CNT_ONE;
                  state    <= S_IDLE;
               end else begin
                  trap_vec_bo  <= vec_base + {22'b0, code_q, 2'b00};
                  trap_code_bo <= code_q;
                  state        <= S_TRAP;
               end
            end
            S_TRAP: begin
               if (trap_taken_i) begin
                  srv_cnt <= srv_cnt + CNT_ONE;
                  state   <= S_SERVICE;
               end
            end
            default: begin
               if (irq_ret_i) begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

   // Decoded from the state register, so async reset cuts these pulses at once
   assign irq_ack_o  = (state == S_ACK);
   assign trap_req_o = (state == S_TRAP);
   assign busy_o     = (state != S_IDLE);

   always_comb begin
      cfg_rdata_bo = 32'h0;
      case (cfg_addr_i)
         A_CTRL:  cfg_rdata_bo = {31'b0, enable};
         A_VEC:   cfg_rdata_bo = vec_base;
         A_SRV:   cfg_rdata_bo = 32'(srv_cnt);
         A_SPUR:  cfg_rdata_bo = 32'(spur_cnt);
         default: cfg_rdata_bo = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_irq_receiver.sv
// Self-checking bench for irq_receiver: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_irq_receiver;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        irq_req_i;
   logic [7:0]  irq_code_bi;
   logic        irq_ack_o;
   logic        cfg_we_i;
   logic [1:0]  cfg_addr_i;
   logic [31:0] cfg_wdata_bi;
   logic [31:0] cfg_rdata_bo;
   logic        trap_req_o;
   logic [31:0] trap_vec_bo;
   logic [7:0]  trap_code_bo;
   logic        trap_taken_i;
   logic        irq_ret_i;
   logic        busy_o;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [31:0] m_vec_base;
   int          m_srv;
   int          m_spur;
   logic [7:0]  m_last_code;

   irq_receiver #(.CNT_W(16), .VEC_RST(32'h0000_0100)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .irq_req_i(irq_req_i), .irq_code_bi(irq_code_bi), .irq_ack_o(irq_ack_o),
      .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_bi(cfg_wdata_bi),
      .cfg_rdata_bo(cfg_rdata_bo),
      .trap_req_o(trap_req_o), .trap_vec_bo(trap_vec_bo), .trap_code_bo(trap_code_bo),
      .trap_taken_i(trap_taken_i), .irq_ret_i(irq_ret_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic write_cfg(input logic [1:0] a, input logic [31:0] d);
      cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_bi = d;
      tick();
      cfg_we_i = 1'b0;
   endtask

   task automatic read_cfg(input logic [1:0] a, output logic [31:0] d);
      cfg_addr_i = a;
      #0.1;
      d = cfg_rdata_bo;
   endtask

   task automatic model_reset;
      m_vec_base = 32'h100; m_srv = 0; m_spur = 0; m_last_code = 8'h00;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      rst_i = 1'b1; irq_req_i = 0; irq_code_bi = 0; cfg_we_i = 0; cfg_addr_i = 0;
      cfg_wdata_bi = 0; trap_taken_i = 0; irq_ret_i = 0;
      model_reset();
      tick(); tick();
      tests++; if (irq_ack_o !== 1'b0) begin fails++; $display("FAIL reset_ack got %b exp 0", irq_ack_o); end
      tests++; if (trap_req_o !== 1'b0) begin fails++; $display("FAIL reset_trap_req got %b exp 0", trap_req_o); end
      tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy_o); end
      tests++; if (trap_vec_bo !== 32'h0) begin fails++; $display("FAIL reset_vec got %h exp 0", trap_vec_bo); end
      tests++; if (trap_code_bo !== 8'h0) begin fails++; $display("FAIL reset_code got %h exp 0", trap_code_bo); end
      read_cfg(2'd0, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl got %h exp 0", d); end
      read_cfg(2'd1, d);
      tests++; if (d !== 32'h100) begin fails++; $display("FAIL reset_vecbase got %h exp 100", d); end
      read_cfg(2'd2, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_srv got %h exp 0", d); end
      read_cfg(2'd3, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_spur got %h exp 0", d); end
      rst_i = 1'b0;
      tick();
   endtask

   // Full transaction against the model; optionally rewrites VEC_BASE in the ACK cycle.
   task automatic run_irq(input logic [7:0] code, input int taken_delay,
                          input bit ret_with_taken, input bit vec_write_in_ack,
                          input logic [31:0] new_vec, input string tag);
      logic [31:0] exp_vec;
      logic [31:0] d;
      irq_req_i = 1'b1; irq_code_bi = code;
      tick();
      tests++; if (irq_ack_o !== 1'b1) begin fails++; $display("FAIL %s ack_n1 got %b exp 1", tag, irq_ack_o); end
      tests++; if (trap_req_o !== 1'b0) begin fails++; $display("FAIL %s trap_req_n1 got %b exp 0", tag, trap_req_o); end
      irq_req_i = 1'b0; irq_code_bi = $urandom;
      exp_vec = m_vec_base + 32'(code) * 32'd4;
      if (vec_write_in_ack) begin
         write_cfg(2'd1, new_vec);
         m_vec_base = new_vec & 32'hFFFF_FFFC;
      end else begin
         tick();
      end
      tests++; if (irq_ack_o !== 1'b0) begin fails++; $display("FAIL %s ack_n2 got %b exp 0", tag, irq_ack_o); end
      if (code == 8'h00) begin
         m_spur++;
         tests++; if (busy_o !== 1'b0 || trap_req_o !== 1'b0) begin fails++; $display("FAIL %s spur_idle busy %b trap %b exp 0 0", tag, busy_o, trap_req_o); end
         tests++; if (trap_code_bo !== m_last_code) begin fails++; $display("FAIL %s spur_code_hold got %h exp %h", tag, trap_code_bo, m_last_code); end
         read_cfg(2'd3, d);
         tests++; if (d !== 32'(m_spur % 65536)) begin fails++; $display("FAIL %s spur_cnt got %0d exp %0d", tag, d, m_spur); end
         return;
      end
      m_last_code = code;
      tests++; if (trap_req_o !== 1'b1) begin fails++; $display("FAIL %s trap_req_n2 got %b exp 1", tag, trap_req_o); end
      tests++; if (trap_vec_bo !== exp_vec) begin fails++; $display("FAIL %s vec got %h exp %h", tag, trap_vec_bo, exp_vec); end
      tests++; if (trap_code_bo !== code) begin fails++; $display("FAIL %s code got %h exp %h", tag, trap_code_bo, code); end
      for (int i = 0; i < taken_delay; i++) begin
         irq_ret_i = $urandom_range(0, 1);
         irq_req_i = $urandom_range(0, 1);
         tick();
         tests++; if (trap_req_o !== 1'b1 || trap_vec_bo !== exp_vec) begin fails++; $display("FAIL %s trap_hold req %b vec %h exp 1 %h", tag, trap_req_o, trap_vec_bo, exp_vec); end
      end
      irq_req_i = 1'b0;
      trap_taken_i = 1'b1; irq_ret_i = ret_with_taken;
      tick();
      m_srv++;
      trap_taken_i = 1'b0; irq_ret_i = 1'b0;
      tests++; if (trap_req_o !== 1'b0 || busy_o !== 1'b1) begin fails++; $display("FAIL %s service trap %b busy %b exp 0 1", tag, trap_req_o, busy_o); end
      read_cfg(2'd2, d);
      tests++; if (d !== 32'(m_srv % 65536)) begin fails++; $display("FAIL %s srv_cnt got %0d exp %0d", tag, d, m_srv); end
      trap_taken_i = 1'b1;
      tick();
      trap_taken_i = 1'b0;
      tests++; if (busy_o !== 1'b1 || trap_code_bo !== code) begin fails++; $display("FAIL %s service_hold busy %b code %h exp 1 %h", tag, busy_o, trap_code_bo, code); end
      irq_ret_i = 1'b1;
      tick();
      irq_ret_i = 1'b0;
      tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL %s ret_idle busy got %b exp 0", tag, busy_o); end
   endtask

   task automatic test_basic;
      write_cfg(2'd0, 32'h1);
      write_cfg(2'd1, 32'h100);
      m_vec_base = 32'h100;
      run_irq(8'h5A, 0, 1'b0, 1'b0, 32'h0, "basic");
      tests++; if (trap_vec_bo !== 32'h268) begin fails++; $display("FAIL basic_vec_abs got %h exp 268", trap_vec_bo); end
   endtask

   task automatic test_disabled;
      logic [31:0] d;
      write_cfg(2'd0, 32'h0);
      irq_req_i = 1'b1; irq_code_bi = 8'h11;
      tick(); tick(); tick();
      tests++; if (irq_ack_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL disabled ack %b busy %b exp 0 0", irq_ack_o, busy_o); end
      write_cfg(2'd0, 32'hFFFF_FFFF);
      tests++; if (irq_ack_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL enable_write_edge ack %b busy %b exp 0 0", irq_ack_o, busy_o); end
      read_cfg(2'd0, d);
      tests++; if (d !== 32'h1) begin fails++; $display("FAIL ctrl_read got %h exp 1", d); end
      tick();
      tests++; if (irq_ack_o !== 1'b1) begin fails++; $display("FAIL enable_ack got %b exp 1", irq_ack_o); end
      irq_req_i = 1'b0;
      tick();
      m_last_code = 8'h11;
      trap_taken_i = 1'b1; tick(); trap_taken_i = 1'b0; m_srv++;
      // clearing enable in service does not abort
      write_cfg(2'd0, 32'h0);
      tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL disable_mid busy got %b exp 1", busy_o); end
      irq_ret_i = 1'b1; tick(); irq_ret_i = 1'b0;
      write_cfg(2'd0, 32'h1);
   endtask

   task automatic test_spurious;
      run_irq(8'h00, 0, 1'b0, 1'b0, 32'h0, "spurious");
   endtask

   task automatic test_pending_during_service;
      logic [31:0] d;
      irq_req_i = 1'b1; irq_code_bi = 8'h21;
      tick(); irq_req_i = 1'b0; tick();
      trap_taken_i = 1'b1; tick(); trap_taken_i = 1'b0; m_srv++; m_last_code = 8'h21;
      irq_req_i = 1'b1; irq_code_bi = 8'h33;
      tick(); tick();
      tests++; if (irq_ack_o !== 1'b0 || busy_o !== 1'b1) begin fails++; $display("FAIL pending_no_ack ack %b busy %b exp 0 1", irq_ack_o, busy_o); end
      irq_ret_i = 1'b1; tick(); irq_ret_i = 1'b0;
      tests++; if (irq_ack_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL pending_ret_idle ack %b busy %b exp 0 0", irq_ack_o, busy_o); end
      irq_req_i = 1'b0;
      run_irq(8'h33, 1, 1'b0, 1'b0, 32'h0, "pending");
      read_cfg(2'd2, d);
      tests++; if (d !== 32'(m_srv)) begin fails++; $display("FAIL pending_srv got %0d exp %0d", d, m_srv); end
   endtask

   task automatic test_wrap;
      logic [31:0] d;
      write_cfg(2'd1, 32'hFFFF_FFFC);
      m_vec_base = 32'hFFFF_FFFC;
      run_irq(8'h01, 0, 1'b1, 1'b0, 32'h0, "wrap");
      tests++; if (trap_vec_bo !== 32'h0) begin fails++; $display("FAIL wrap_vec got %h exp 0", trap_vec_bo); end
      write_cfg(2'd1, 32'h203);
      m_vec_base = 32'h200;
      read_cfg(2'd1, d);
      tests++; if (d !== 32'h200) begin fails++; $display("FAIL vec_mask got %h exp 200", d); end
      write_cfg(2'd2, 32'h55);
      write_cfg(2'd3, 32'h77);
      read_cfg(2'd2, d);
      tests++; if (d !== 32'(m_srv)) begin fails++; $display("FAIL srv_ro got %0d exp %0d", d, m_srv); end
      read_cfg(2'd3, d);
      tests++; if (d !== 32'(m_spur)) begin fails++; $display("FAIL spur_ro got %0d exp %0d", d, m_spur); end
   endtask

   task automatic test_reset_midflight;
      logic [31:0] d;
      irq_req_i = 1'b1; irq_code_bi = 8'h44;
      tick(); irq_req_i = 1'b0; tick();
      tests++; if (trap_req_o !== 1'b1) begin fails++; $display("FAIL rst_trap_pre got %b exp 1", trap_req_o); end
      rst_i = 1'b1; #1;
      tests++; if (trap_req_o !== 1'b0 || busy_o !== 1'b0 || trap_vec_bo !== 32'h0) begin fails++; $display("FAIL rst_in_trap req %b busy %b vec %h exp 0 0 0", trap_req_o, busy_o, trap_vec_bo); end
      model_reset();
      read_cfg(2'd2, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_srv got %0d exp 0", d); end
      read_cfg(2'd1, d);
      tests++; if (d !== 32'h100) begin fails++; $display("FAIL rst_vecbase got %h exp 100", d); end
      tick(); rst_i = 1'b0; tick();
      write_cfg(2'd0, 32'h1);
      irq_req_i = 1'b1; irq_code_bi = 8'h00;
      tick(); irq_req_i = 1'b0;
      tests++; if (irq_ack_o !== 1'b1) begin fails++; $display("FAIL rst_ack_pre got %b exp 1", irq_ack_o); end
      rst_i = 1'b1; #1;
      tests++; if (irq_ack_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL rst_in_ack ack %b busy %b exp 0 0", irq_ack_o, busy_o); end
      read_cfg(2'd0, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_ctrl got %h exp 0", d); end
      tick(); rst_i = 1'b0; tick();
      read_cfg(2'd3, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_spur_cut got %0d exp 0", d); end
      write_cfg(2'd0, 32'h1);
   endtask

   task automatic test_random;
      logic [7:0]  code;
      logic [31:0] nv;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            nv = $urandom;
            write_cfg(2'd1, nv);
            m_vec_base = nv & 32'hFFFF_FFFC;
         end
         code = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         nv = $urandom;
         run_irq(code, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), nv, $sformatf("rand%0d", n));
         for (int i = 0; i < $urandom_range(0, 2); i++) tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_disabled();
      test_spurious();
      test_pending_during_service();
      test_wrap();
      test_reset_midflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
